// File: rtl/easy_fifo_axis_downsizer.sv
// AXI-Stream width downsizer placed after an AXIS FIFO.
// Holds one wide beat and replays it as S_DWIDTH/M_DWIDTH narrow beats,
// least-significant slice first, trimming trailing null (tkeep == 0) slices.
// Sideband (tdest/tuser/tid) is repeated on every narrow beat; tlast is
// asserted only on the final emitted slice.
module easy_fifo_axis_downsizer #(
    parameter int S_DWIDTH   = 64,
    parameter int M_DWIDTH   = 16,
    parameter int HAS_KEEP   = 1,
    parameter int HAS_LAST   = 1,
    parameter int DEST_WIDTH = 0,
    parameter int USER_WIDTH = 0,
    parameter int ID_WIDTH   = 0,
    // derived widths, not meant to be overridden
    parameter int SKW = S_DWIDTH / 8,
    parameter int MKW = M_DWIDTH / 8,
    parameter int DW  = (DEST_WIDTH > 0) ? DEST_WIDTH : 1,
    parameter int UW  = (USER_WIDTH > 0) ? USER_WIDTH : 1,
    parameter int IW  = (ID_WIDTH   > 0) ? ID_WIDTH   : 1
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [S_DWIDTH-1:0] s_axis_tdata,
    input  logic [SKW-1:0]      s_axis_tkeep,
    input  logic                s_axis_tlast,
    input  logic [DW-1:0]       s_axis_tdest,
    input  logic [UW-1:0]       s_axis_tuser,
    input  logic [IW-1:0]       s_axis_tid,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,

    output logic [M_DWIDTH-1:0] m_axis_tdata,
    output logic [MKW-1:0]      m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic [DW-1:0]       m_axis_tdest,
    output logic [UW-1:0]       m_axis_tuser,
    output logic [IW-1:0]       m_axis_tid,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready
);

    localparam int RATIO = S_DWIDTH / M_DWIDTH;
    localparam int IDXW  = $clog2(RATIO);

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    state_t              state_q;
    logic [S_DWIDTH-1:0] data_q;
    logic [SKW-1:0]      keep_q;
    logic                last_q;
    logic [DW-1:0]       dest_q;
    logic [UW-1:0]       user_q;
    logic [IW-1:0]       id_q;
    logic [IDXW-1:0]     idx_q;
    logic [IDXW-1:0]     last_idx_q;

    logic [SKW-1:0]      keep_in;
    logic                last_in;
    logic [IDXW-1:0]     last_idx_d;
    logic                any_keep;
    logic                final_slice;
    logic                accept;
    logic                drop;

    // Decode the incoming beat: effective keep/last and highest non-null slice.
    always_comb begin
        keep_in    = (HAS_KEEP != 0) ? s_axis_tkeep : {SKW{1'b1}};
        last_in    = (HAS_LAST != 0) && s_axis_tlast;
        last_idx_d = '0;
        any_keep   = 1'b0;
        for (int i = 0; i < RATIO; i++) begin
            if (keep_in[i*MKW +: MKW] != '0) begin
                last_idx_d = IDXW'(i);
                any_keep   = 1'b1;
            end
        end
    end

    assign final_slice = (idx_q == last_idx_q);

    // Ready while empty, or when the last slice of the held beat leaves this
    // cycle; this is what lets a new wide beat follow with no bubble. Forced
    // low while reset is asserted.
    assign s_axis_tready = !rst &&
                           ((state_q == EMPTY) || (m_axis_tready && final_slice));
    assign accept        = s_axis_tvalid && s_axis_tready;
    // A wholly null beat without tlast carries nothing worth emitting.
    assign drop          = !any_keep && !last_in;

    // Holding register, slice index and EMPTY/SEND state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            data_q     <= '0;
            keep_q     <= '0;
            last_q     <= 1'b0;
            dest_q     <= '0;
            user_q     <= '0;
            id_q       <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
        end else if (accept) begin
            data_q     <= s_axis_tdata;
            keep_q     <= keep_in;
            last_q     <= last_in;
            dest_q     <= (DEST_WIDTH > 0) ? s_axis_tdest : '0;
            user_q     <= (USER_WIDTH > 0) ? s_axis_tuser : '0;
            id_q       <= (ID_WIDTH   > 0) ? s_axis_tid   : '0;
            last_idx_q <= last_idx_d;
            idx_q      <= '0;
            state_q    <= drop ? EMPTY : SEND;
        end else if (state_q == SEND && m_axis_tready) begin
            if (final_slice) begin
                idx_q   <= '0;
                state_q <= EMPTY;
            end else begin
                idx_q   <= idx_q + 1'b1;
            end
        end
    end

    // Narrow outputs are pure selects of held registers; nothing from s_* leaks through.
    always_comb begin
        m_axis_tvalid = (state_q == SEND);
        m_axis_tdata  = data_q[idx_q*M_DWIDTH +: M_DWIDTH];
        m_axis_tkeep  = (HAS_KEEP != 0) ? keep_q[idx_q*MKW +: MKW] : {MKW{1'b1}};
        m_axis_tlast  = (HAS_LAST != 0) && last_q && final_slice;
        m_axis_tdest  = dest_q;
        m_axis_tuser  = user_q;
        m_axis_tid    = id_q;
    end

endmodule

// File: tb/tb_easy_fifo_axis_downsizer.sv
// Directed bench for easy_fifo_axis_downsizer at S=64, M=16.
module tb_easy_fifo_axis_downsizer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tlast = 1'b0;
    logic [0:0]  s_axis_tdest = '0;
    logic [0:0]  s_axis_tuser = '0;
    logic [0:0]  s_axis_tid   = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [15:0] m_axis_tdata;
    logic [1:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic [0:0]  m_axis_tdest;
    logic [0:0]  m_axis_tuser;
    logic [0:0]  m_axis_tid;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;

    easy_fifo_axis_downsizer #(
        .S_DWIDTH(64), .M_DWIDTH(16), .HAS_KEEP(1), .HAS_LAST(1),
        .DEST_WIDTH(0), .USER_WIDTH(0), .ID_WIDTH(0)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tdest(s_axis_tdest),
        .s_axis_tuser(s_axis_tuser), .s_axis_tid(s_axis_tid),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tdest(m_axis_tdest),
        .m_axis_tuser(m_axis_tuser), .m_axis_tid(m_axis_tid),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  k;
        logic        l;
        int          c;
        logic        r;
    } ob_t;

    ob_t outq[$];
    ob_t expq[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    bit  rnd_rdy = 0;

    // stall-stability tracking
    bit          stall_q = 0;
    logic [15:0] hold_d;
    logic [1:0]  hold_k;
    logic        hold_l;

    always @(posedge clk) cyc <= cyc + 1;

    // Random downstream backpressure when enabled.
    always begin
        @(posedge clk);
        #1;
        if (rnd_rdy) m_axis_tready = 1'($urandom_range(0, 1));
    end

    // Output monitor: inputs change 1 after posedge, so negedge shows the
    // values that the next posedge will see.
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_q) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hold_d ||
                    m_axis_tkeep !== hold_k || m_axis_tlast !== hold_l) begin
                    errors++;
                    $display("FAIL stall_stable: got v=%b d=%h k=%b l=%b want v=1 d=%h k=%b l=%b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                             hold_d, hold_k, hold_l);
                end
            end
            if (m_axis_tvalid && m_axis_tready)
                outq.push_back('{d: m_axis_tdata, k: m_axis_tkeep, l: m_axis_tlast,
                                 c: cyc, r: s_axis_tready});
            stall_q = m_axis_tvalid && !m_axis_tready;
            hold_d  = m_axis_tdata;
            hold_k  = m_axis_tkeep;
            hold_l  = m_axis_tlast;
        end else begin
            stall_q = 0;
        end
    end

    // Present a wide beat and wait for its acceptance; leaves tvalid high.
    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                             output int acc);
        bit ok = 0;
        acc = -1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int n = 0; n < 500 && !ok; n++) begin
            @(negedge clk);
            if (s_axis_tready) begin
                ok  = 1;
                acc = cyc;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: beat %h not accepted, want accept within 500 cycles", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        s_axis_tvalid = 1'b0;
    endtask

    // Wait (bounded) for n outputs, then confirm no extras appear.
    task automatic wait_out(input int n, input string nm);
        int t = 0;
        while (outq.size() < n && t < 5000) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (outq.size() != n) begin
            errors++;
            $display("FAIL %s_count: got %0d narrow beats want %0d", nm, outq.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: got mvalid=%b sready=%b want 0 0", m_axis_tvalid, s_axis_tready);
        end
        checks++;
        if (m_axis_tdata !== 16'h0 || m_axis_tkeep !== 2'b00 || m_axis_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got d=%h k=%b l=%b want 0000 00 0", m_axis_tdata, m_axis_tkeep, m_axis_tlast);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", s_axis_tready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_beat();
        logic [15:0] ed[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        int acc;
        outq.delete();
        m_axis_tready = 1'b1;
        send_beat(64'h4444_3333_2222_1111, 8'hFF, 1'b1, acc);
        idle_in();
        wait_out(4, "full");
        for (int i = 0; i < 4 && i < outq.size(); i++) begin
            checks++;
            if (outq[i].d !== ed[i] || outq[i].k !== 2'b11 || outq[i].l !== (i == 3) ||
                outq[i].c != acc + 1 + i) begin
                errors++;
                $display("FAIL full_slice%0d: got d=%h k=%b l=%b cyc=%0d want d=%h k=11 l=%b cyc=%0d",
                         i, outq[i].d, outq[i].k, outq[i].l, outq[i].c, ed[i], (i == 3), acc + 1 + i);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ed[8] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003,
                               16'hB000, 16'hB001, 16'hB002, 16'hB003};
        int acc1, acc2;
        outq.delete();
        m_axis_tready = 1'b1;
        send_beat(64'hA003_A002_A001_A000, 8'hFF, 1'b0, acc1);
        send_beat(64'hB003_B002_B001_B000, 8'hFF, 1'b1, acc2);
        idle_in();
        checks++;
        if (acc2 != acc1 + 4) begin
            errors++;
            $display("FAIL b2b_accept: second beat accepted at cycle %0d want %0d", acc2, acc1 + 4);
        end
        wait_out(8, "b2b");
        for (int i = 0; i < 8 && i < outq.size(); i++) begin
            checks++;
            if (outq[i].d !== ed[i] || outq[i].l !== (i == 7) || outq[i].c != acc1 + 1 + i ||
                outq[i].r !== (i == 3 || i == 7)) begin
                errors++;
                $display("FAIL b2b_beat%0d: got d=%h l=%b cyc=%0d sready=%b want d=%h l=%b cyc=%0d sready=%b",
                         i, outq[i].d, outq[i].l, outq[i].c, outq[i].r,
                         ed[i], (i == 7), acc1 + 1 + i, (i == 3 || i == 7));
            end
        end
    endtask

    task automatic test_partial_keep();
        logic [15:0] ed[4] = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
        logic [1:0]  ek[4] = '{2'b11, 2'b00, 2'b00, 2'b11};
        int acc;
        outq.delete();
        m_axis_tready = 1'b1;
        send_beat(64'hDDDD_CCCC_BBBB_AAAA, 8'h0F, 1'b1, acc);
        idle_in();
        wait_out(2, "keep0F");
        if (outq.size() == 2) begin
            checks++;
            if (outq[0].d !== 16'hAAAA || outq[0].k !== 2'b11 || outq[0].l !== 1'b0 ||
                outq[1].d !== 16'hBBBB || outq[1].k !== 2'b11 || outq[1].l !== 1'b1) begin
                errors++;
                $display("FAIL keep0F_data: got %h/%b/%b %h/%b/%b want aaaa/11/0 bbbb/11/1",
                         outq[0].d, outq[0].k, outq[0].l, outq[1].d, outq[1].k, outq[1].l);
            end
        end
        outq.delete();
        send_beat(64'h0D0D_0C0C_0B0B_0A0A, 8'hC3, 1'b1, acc);
        idle_in();
        wait_out(4, "keepC3");
        for (int i = 0; i < 4 && i < outq.size(); i++) begin
            checks++;
            if (outq[i].d !== ed[i] || outq[i].k !== ek[i] || outq[i].l !== (i == 3)) begin
                errors++;
                $display("FAIL keepC3_slice%0d: got d=%h k=%b l=%b want d=%h k=%b l=%b",
                         i, outq[i].d, outq[i].k, outq[i].l, ed[i], ek[i], (i == 3));
            end
        end
    endtask

    task automatic test_null_beats();
        int acc;
        outq.delete();
        m_axis_tready = 1'b1;
        send_beat(64'h1234_5678_9ABC_DEF0, 8'h00, 1'b0, acc);
        idle_in();
        checks++;
        if (acc < 0) begin
            errors++;
            $display("FAIL null_drop_accept: got no accept want accepted");
        end
        wait_out(0, "null_drop");
        send_beat(64'h1234_5678_9ABC_5555, 8'h00, 1'b1, acc);
        idle_in();
        wait_out(1, "null_last");
        if (outq.size() == 1) begin
            checks++;
            if (outq[0].d !== 16'h5555 || outq[0].k !== 2'b00 || outq[0].l !== 1'b1) begin
                errors++;
                $display("FAIL null_last_beat: got d=%h k=%b l=%b want 5555 00 1",
                         outq[0].d, outq[0].k, outq[0].l);
            end
        end
    endtask

    task automatic test_random_stall();
        int acc, nsl, hi, t, nbad;
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        outq.delete();
        expq.delete();
        rnd_rdy = 1;
        for (int b = 0; b < 200; b++) begin
            d   = {32'($urandom), 32'($urandom)};
            k   = 8'($urandom);
            nsl = $urandom_range(0, 4);
            k   = k & 8'((16'h1 << (2 * nsl)) - 16'h1);
            if ($urandom_range(0, 3) == 0) k[3:2] = 2'b00;
            l   = 1'($urandom_range(0, 1));
            hi  = -1;
            for (int s = 0; s < 4; s++) if (k[2*s +: 2] != 2'b00) hi = s;
            if (hi < 0) begin
                if (l) expq.push_back('{d: d[15:0], k: 2'b00, l: 1'b1, c: 0, r: 1'b0});
            end else begin
                for (int s = 0; s <= hi; s++)
                    expq.push_back('{d: d[16*s +: 16], k: k[2*s +: 2], l: l && (s == hi), c: 0, r: 1'b0});
            end
            if ($urandom_range(0, 3) == 0) begin
                idle_in();
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_beat(d, k, l, acc);
        end
        idle_in();
        t = 0;
        while (outq.size() < expq.size() && t < 20000) begin
            @(posedge clk);
            t++;
        end
        rnd_rdy = 0;
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (outq.size() != expq.size()) begin
            errors++;
            $display("FAIL random_count: got %0d narrow beats want %0d", outq.size(), expq.size());
        end
        nbad = 0;
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            checks++;
            if (outq[i].d !== expq[i].d || outq[i].k !== expq[i].k || outq[i].l !== expq[i].l) begin
                errors++;
                nbad++;
                if (nbad <= 10)
                    $display("FAIL random_beat%0d: got d=%h k=%b l=%b want d=%h k=%b l=%b",
                             i, outq[i].d, outq[i].k, outq[i].l, expq[i].d, expq[i].k, expq[i].l);
            end
        end
    endtask

    task automatic test_reset_mid_beat();
        logic [15:0] ed[4] = '{16'hD000, 16'hD001, 16'hD002, 16'hD003};
        int acc, t;
        outq.delete();
        m_axis_tready = 1'b1;
        send_beat(64'h8888_7777_6666_5555, 8'hFF, 1'b1, acc);
        idle_in();
        t = 0;
        while (outq.size() < 2 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        // slice 2 is now on the output
        rst = 1'b1;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0 || m_axis_tdata !== 16'h0) begin
            errors++;
            $display("FAIL midrst_outputs: got mvalid=%b sready=%b d=%h want 0 0 0000",
                     m_axis_tvalid, s_axis_tready, m_axis_tdata);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        outq.delete();
        send_beat(64'hD003_D002_D001_D000, 8'hFF, 1'b1, acc);
        idle_in();
        wait_out(4, "midrst");
        for (int i = 0; i < 4 && i < outq.size(); i++) begin
            checks++;
            if (outq[i].d !== ed[i] || outq[i].l !== (i == 3)) begin
                errors++;
                $display("FAIL midrst_slice%0d: got d=%h l=%b want d=%h l=%b",
                         i, outq[i].d, outq[i].l, ed[i], (i == 3));
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_full_beat();
        test_back_to_back();
        test_partial_keep();
        test_null_beats();
        test_random_stall();
        test_reset_mid_beat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
